// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch-queue entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: flushable synchronous FIFO of fetched {pc, instr} entries with occupancy count
module fetch_queue import riscv_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  output entry_t        data_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty_o = count_o == '0;
  assign full_o = count_o == (AW+1)'(DEPTH);
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_o <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= data_i;
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count_o <= count_o + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited imem requests, redirect/kill logic around fetch_queue
module fetch_unit #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(riscv_pkg::RESET_VECTOR),
  parameter int FQ_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] jump_pc_i,
  input  logic            jump_pc_valid_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;
  logic [XLEN-1:0] pc_q, inflight_pc_q;
  logic inflight_q, kill_q, push, pop, empty, full;
  logic [CW-1:0] count;
  logic [CW:0] credit;
  entry_t resp, head;
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign imem_req_o = rstn_i && !jump_pc_valid_i && credit < (CW+1)'(FQ_DEPTH);
  assign imem_addr_o = pc_q;
  assign resp = '{pc: inflight_pc_q, instr: imem_rdata_i};
  assign push = inflight_q && !kill_q && !full;
  assign pop = instr_valid_o && instr_ready_i;
  assign instr_valid_o = !empty;
  assign instr_o = head.instr;
  assign pc_o = head.pc;
  fetch_queue #(.DEPTH(FQ_DEPTH), .entry_t(entry_t)) u_fq (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (jump_pc_valid_i),
    .push_i  (push),
    .data_i  (resp),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      pc_q <= RESET_VECTOR;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      kill_q <= 1'b0;
    end else begin
      pc_q <= jump_pc_valid_i ? {jump_pc_i[XLEN-1:2], 2'b00} : imem_req_o ? pc_q + XLEN'(4) : pc_q;
      inflight_q <= imem_req_o;
      inflight_pc_q <= imem_req_o ? pc_q : inflight_pc_q;
      kill_q <= jump_pc_valid_i && inflight_q;
    end
endmodule
